scaler_linebuf_ctrl: RTL

- Ping-pong line-buffer scheduler between the scaler line writer (fills BRAM banks PING/PONG) and the vout read-all stage (drains them).
- Tracks bank occupancy, gives the writer its bank select and a write allow, and gives the reader a line-ready status.
- Counts written and read lines per frame and ends the frame after the last read.
- Sits in the core_clk domain beside the vout reader; all status is registered.

---
 rtl/scaler_linebuf_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/scaler_linebuf_ctrl.sv
// Ping-pong line-buffer scheduler between the scaler line writer and the vout reader.
// Tracks PING/PONG occupancy, hands out bank selects and counts lines to end each frame.
module scaler_linebuf_ctrl #(
   parameter int IMG_V_MAX      = 1080,
   parameter int IMG_V_BITWIDTH = $clog2(IMG_V_MAX),
   parameter int PIXEL_NUM      = 1
) (
   input  logic                      core_clk,
   input  logic                      core_rst,
   input  logic                      core_start,
   input  logic [IMG_V_BITWIDTH-1:0] core_arg_img_des_v,
   output logic                      wr_allow,
   output logic                      wr_bank,
   input  logic                      wdone,
   output logic [PIXEL_NUM-1:0]      rempty,
   output logic                      rd_bank,
   input  logic                      rdone,
   output logic                      core_busy,
   output logic                      core_done,
   output logic                      err_ovf,
   output logic                      err_udf
);

   // One extra counter bit so saturation at des_v+1 can never wrap.
   localparam int CNT_W = IMG_V_BITWIDTH + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t                    state, state_next;
   logic [1:0]                occ, occ_next;
   logic [CNT_W-1:0]          wr_cnt, wr_cnt_next;
   logic [CNT_W-1:0]          rd_cnt, rd_cnt_next;
   logic [IMG_V_BITWIDTH-1:0] des_v_latched, des_v_next;
   logic                      wr_bank_next, rd_bank_next;
   logic                      err_ovf_next, err_udf_next;
   logic                      wd_ok, rd_ok;
   logic [CNT_W-1:0]          des_ext, cnt_max;

   assign des_ext = {1'b0, des_v_latched};
   assign cnt_max = des_ext + CNT_W'(1);

   // A write into a full pair is still legal when a read frees a bank in the same cycle.
   assign rd_ok = rdone && (occ != 2'd0);
   assign wd_ok = wdone && ((occ != 2'd2) || rdone);

   always_comb begin
      state_next   = state;
      occ_next     = occ;
      wr_cnt_next  = wr_cnt;
      rd_cnt_next  = rd_cnt;
      des_v_next   = des_v_latched;
      wr_bank_next = wr_bank;
      rd_bank_next = rd_bank;
      err_ovf_next = err_ovf;
      err_udf_next = err_udf;
      case (state)
         ST_IDLE: begin
            if (core_start) begin
               des_v_next   = core_arg_img_des_v;
               occ_next     = 2'd0;
               wr_cnt_next  = '0;
               rd_cnt_next  = '0;
               wr_bank_next = 1'b0;
               rd_bank_next = 1'b0;
               err_ovf_next = 1'b0;
               err_udf_next = 1'b0;
               state_next   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (wd_ok) begin
               wr_bank_next = ~wr_bank;
               if (wr_cnt != cnt_max) wr_cnt_next = wr_cnt + CNT_W'(1);
            end
            if (rd_ok) begin
               rd_bank_next = ~rd_bank;
               if (rd_cnt != cnt_max) rd_cnt_next = rd_cnt + CNT_W'(1);
               if (rd_cnt == des_ext) state_next = ST_DONE;
            end
            if (wd_ok && !rd_ok)      occ_next = occ + 2'd1;
            else if (rd_ok && !wd_ok) occ_next = occ - 2'd1;
            if (wdone && !wd_ok) err_ovf_next = 1'b1;
            if (rdone && !rd_ok) err_udf_next = 1'b1;
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         state         <= ST_IDLE;
         occ           <= 2'd0;
         wr_cnt        <= '0;
         rd_cnt        <= '0;
         des_v_latched <= '0;
         wr_bank       <= 1'b0;
         rd_bank       <= 1'b0;
         err_ovf       <= 1'b0;
         err_udf       <= 1'b0;
      end else begin
         state         <= state_next;
         occ           <= occ_next;
         wr_cnt        <= wr_cnt_next;
         rd_cnt        <= rd_cnt_next;
         des_v_latched <= des_v_next;
         wr_bank       <= wr_bank_next;
         rd_bank       <= rd_bank_next;
         err_ovf       <= err_ovf_next;
         err_udf       <= err_udf_next;
      end
   end

   // Status is decoded straight from registers, so it moves the cycle after each event.
   always_comb begin
      rempty    = '0;
      rempty[0] = (occ != 2'd0);
   end

   assign wr_allow  = (state == ST_RUN) && (occ != 2'd2) && (wr_cnt <= des_ext);
   assign core_busy = (state == ST_RUN);
   assign core_done = (state == ST_DONE);

endmodule
